preset_sequencer: RTL and testbench
===================================

Name: preset_sequencer

Overview:
- Drives the PRESET pin of DFFP banks (and the CLEAR pin of DFFC banks) in Gowin-targeted designs simulated under Verilator.
- PRESET asserts asynchronously when RESETN falls, releases synchronously after a programmable hold, and can also be pulsed by a 4-phase REQ/ACK handshake from user logic.
- Sits between the board reset and the register banks built from the DFF primitives.

Parameters:
- SYNC_STAGES, 2, depth of the RESETN release synchronizer; legal range 2..4.
- HOLD_CYCLES, 16, number of cycles PRESET stays high after the synchronized release; legal range 1..65535.
- PULSE_CYCLES, 4, width in cycles of a software-requested PRESET pulse; legal range 1..65535.
- CNT_W, 16, width of the shared down-counter; must hold max(HOLD_CYCLES, PULSE_CYCLES).

Ports:
- CLK  input  1  Rising-edge clock.
- RESETN  input  1  Asynchronous, active-low reset.
- REQ  input  1  Software preset request, 4-phase level handshake; synchronous to CLK.
- ACK  output  1  Handshake acknowledge.
- PRESET  output  1  Active-high preset for DFFP banks; asserted asynchronously, released synchronously.
- READY  output  1  High when in IDLE and able to accept REQ.

Behaviour:
- RESETN low (async):
  - PRESET=1, ACK=0, READY=0.
  - Synchronizer cleared to 0, counter cleared to 0, armed flag cleared, state=SYNC.
- SYNC: the synchronizer shifts in 1 each edge. When the last stage becomes 1:
  - Counter loads HOLD_CYCLES-1.
  - State=HOLD.
- HOLD:
  - Counter decrements each edge.
  - On the edge where counter==0: PRESET<=0, READY<=1, state=IDLE.
  - Net effect: PRESET falls on the (SYNC_STAGES+HOLD_CYCLES)th rising edge with RESETN high, counting the first edge as 1.
- Armed flag: set on any edge where REQ is sampled low. REQ is ignored until armed. A REQ held high through reset therefore triggers nothing.
- IDLE: if armed and REQ sampled high on edge k, then at edge k:
  - PRESET<=1, READY<=0.
  - Counter loads PULSE_CYCLES-1.
  - State=PULSE.
- PULSE:
  - Counter decrements each edge.
  - On the edge where counter==0: PRESET<=0, ACK<=1, state=ACKW.
  - PRESET is high for exactly PULSE_CYCLES cycles.
  - REQ is ignored during PULSE, including REQ dropping early.
- ACKW: on the first edge REQ is sampled low: ACK<=0, READY<=1, state=IDLE.
  - A new request needs REQ sampled high on a later edge while in IDLE.
- Outputs:
  - All outputs are registered. No combinational path exists from REQ to any output.
  - PRESET is the only output with an asynchronous set path.
- RESETN low mid-HOLD, mid-PULSE or in ACKW: immediate return to reset values. The counter value is discarded and no ACK is produced for the interrupted request.
- RESETN glitch shorter than one cycle: PRESET still asserts, and the full SYNC+HOLD sequence restarts.
- Counter never wraps. Loads are always ≥0, and it is not decremented in IDLE/ACKW.

Optional Feature:
- Macro: PRESET_SEQ_COUNT_EN.
- When defined:
  - Adds output PRESET_CNT, 8 bits, reset to 0 by RESETN.
  - Increments on each accepted software request (IDLE→PULSE) and saturates at 255.
  - Adds input CNT_CLR, synchronous, which zeroes PRESET_CNT. CNT_CLR has priority over a simultaneous increment.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset release, defaults: RESETN low 3 cycles then high → PRESET=1 through edge 17, PRESET=0 and READY=1 at edge 18, ACK=0 throughout.
- Software pulse: REQ=1 sampled in IDLE at edge k → PRESET=1 for edges k..k+3, PRESET=0 and ACK=1 at edge k+4; REQ=0 at edge k+6 → ACK=0 and READY=1 at edge k+6.
- REQ high through reset → after release, PRESET stays 0 and READY stays 1 while REQ remains 1; REQ low for 1 cycle then high → one 4-cycle pulse.
- RESETN low at the 2nd cycle of PULSE → PRESET=1 and ACK=0 with no clock edge; after release, the full 18-edge sequence repeats and no stale ACK appears.
- REQ dropped during PULSE → pulse still completes at 4 cycles, ACK=1 for exactly one cycle, then IDLE.
- With PRESET_SEQ_COUNT_EN: 300 requests → PRESET_CNT=255; CNT_CLR asserted together with an accepted request → PRESET_CNT=0.

Source files
------------

// File: rtl/preset_sequencer.sv
// preset_sequencer: async-assert / sync-release PRESET driver with REQ/ACK-triggered pulses.
// Optional accepted-request counter (PRESET_CNT, CNT_CLR) when PRESET_SEQ_COUNT_EN is defined.
module preset_sequencer #(
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 16,
    parameter int PULSE_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       REQ,
`ifdef PRESET_SEQ_COUNT_EN
    input  logic       CNT_CLR,
    output logic [7:0] PRESET_CNT,
`endif
    output logic       ACK,
    output logic       PRESET,
    output logic       READY
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES < 1 || PULSE_CYCLES < 1 ||
        HOLD_CYCLES >= (1 << CNT_W) || PULSE_CYCLES >= (1 << CNT_W)) begin : g_bad_param
        $error("preset_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {SYNC, HOLD, IDLE, PULSE, ACKW} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   armed, preset_n, ack_n, ready_n;
    logic                   cnt_zero, sync_done, accept;

    assign cnt_zero  = cnt == '0;
    assign sync_done = sync[SYNC_STAGES-2];
    assign accept    = state == IDLE && armed && REQ;

    // State, counter, synchronizer, armed flag and registered outputs; reset forces PRESET high at once
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state  <= SYNC;
            sync   <= '0;
            cnt    <= '0;
            armed  <= 1'b0;
            PRESET <= 1'b1;
            ACK    <= 1'b0;
            READY  <= 1'b0;
        end else begin
            state  <= state_n;
            sync   <= {sync[SYNC_STAGES-2:0], 1'b1};
            cnt    <= cnt_n;
            armed  <= armed | ~REQ;
            PRESET <= preset_n;
            ACK    <= ack_n;
            READY  <= ready_n;
        end
    end

    // Next state: REQ only matters in IDLE (once armed) and ACKW
    always_comb begin
        state_n = state;
        case (state)
            SYNC:    state_n = sync_done ? HOLD : SYNC;
            HOLD:    state_n = cnt_zero ? IDLE : HOLD;
            IDLE:    state_n = accept ? PULSE : IDLE;
            PULSE:   state_n = cnt_zero ? ACKW : PULSE;
            ACKW:    state_n = REQ ? ACKW : IDLE;
            default: state_n = SYNC;
        endcase
    end

    // Next output and counter values; the counter only counts down in HOLD and PULSE and stops at zero
    always_comb begin
        cnt_n    = cnt;
        preset_n = PRESET;
        ack_n    = ACK;
        ready_n  = READY;
        case (state)
            SYNC: if (sync_done) cnt_n = CNT_W'(HOLD_CYCLES - 1);
            HOLD: begin
                if (cnt_zero) begin
                    preset_n = 1'b0;
                    ready_n  = 1'b1;
                end else cnt_n = cnt - CNT_W'(1);
            end
            IDLE: begin
                if (accept) begin
                    preset_n = 1'b1;
                    ready_n  = 1'b0;
                    cnt_n    = CNT_W'(PULSE_CYCLES - 1);
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    preset_n = 1'b0;
                    ack_n    = 1'b1;
                end else cnt_n = cnt - CNT_W'(1);
            end
            ACKW: begin
                if (!REQ) begin
                    ack_n   = 1'b0;
                    ready_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef PRESET_SEQ_COUNT_EN
    // Saturating count of accepted requests; a clear wins over a same-cycle increment
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) PRESET_CNT <= '0;
        else if (CNT_CLR) PRESET_CNT <= '0;
        else if (accept && PRESET_CNT != 8'hFF) PRESET_CNT <= PRESET_CNT + 8'd1;
    end
`endif

endmodule

// File: tb/tb_preset_sequencer.sv
// tb_preset_sequencer: vector table, corner sequences and random REQ/reset traffic against a timeline model.
module tb_preset_sequencer;

    localparam int S = 2;
    localparam int H = 16;
    localparam int P = 4;

    logic CLK = 1'b0;
    logic RESETN = 1'b1;
    logic REQ = 1'b0;
    logic ACK, PRESET, READY;
`ifdef PRESET_SEQ_COUNT_EN
    logic       CNT_CLR = 1'b0;
    logic [7:0] PRESET_CNT;
`endif

    always #5 CLK = ~CLK;

    preset_sequencer #(.SYNC_STAGES(S), .HOLD_CYCLES(H), .PULSE_CYCLES(P), .CNT_W(16)) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .REQ(REQ),
`ifdef PRESET_SEQ_COUNT_EN
        .CNT_CLR(CNT_CLR),
        .PRESET_CNT(PRESET_CNT),
`endif
        .ACK(ACK),
        .PRESET(PRESET),
        .READY(READY)
    );

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Timeline model: edges counted since release, pulse end time stamp, ack-wait flag
    int n, pend, m_cnt;
    bit armed, busy, ackw, mp, ma, mr;

    task automatic model_reset();
        n = 0; pend = 0; m_cnt = 0;
        armed = 0; busy = 0; ackw = 0;
        mp = 1; ma = 0; mr = 0;
    endtask

    task automatic model_step(input bit r, input bit c);
        bit acc;
        acc = 0;
        n++;
        if (n < S + H) begin
            mp = 1; mr = 0;
        end else if (n == S + H) begin
            mp = 0; mr = 1;
        end else if (busy) begin
            if (n == pend) begin busy = 0; ackw = 1; mp = 0; ma = 1; end
        end else if (ackw) begin
            if (!r) begin ackw = 0; ma = 0; mr = 1; end
        end else if (armed && r) begin
            busy = 1; pend = n + P; mp = 1; mr = 0; acc = 1;
        end
        if (c) m_cnt = 0;
        else if (acc && m_cnt < 255) m_cnt++;
        armed = armed | !r;
    endtask

    logic [2:0] outs;
    assign outs = {PRESET, ACK, READY};

    task automatic tick(input bit r, input bit c);
        REQ = r;
`ifdef PRESET_SEQ_COUNT_EN
        CNT_CLR = c;
`endif
        @(posedge CLK);
        model_step(r, c);
        #1;
        check("model_outputs", {5'b0, outs}, {5'b0, mp, ma, mr});
`ifdef PRESET_SEQ_COUNT_EN
        check("preset_cnt", PRESET_CNT, m_cnt[7:0]);
`endif
    endtask

    task automatic do_reset(input bit r);
        REQ = r;
        RESETN = 1'b0;
        #1;
        check("reset_async", {5'b0, outs}, 8'b100);
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RESETN = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        bit         req;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit rst, input bit req, input logic [2:0] e, input int rep);
        for (int i = 0; i < rep; i++) tbl.push_back('{rst && i == 0, req, e});
    endfunction

    initial begin
        // Boot with REQ low: PRESET through edge 17, READY at edge 18
        add(1, 0, 3'b100, 17);
        add(0, 0, 3'b001, 2);
        // Pulse at edge k, ACK at k+4, released by REQ low at k+6
        add(0, 1, 3'b100, 4);
        add(0, 1, 3'b010, 2);
        add(0, 0, 3'b001, 1);
        // REQ dropped during the pulse: pulse still 4 cycles, ACK one cycle
        add(0, 1, 3'b100, 1);
        add(0, 0, 3'b100, 3);
        add(0, 0, 3'b010, 1);
        add(0, 0, 3'b001, 2);
        // REQ high through reset: nothing until REQ is seen low once
        add(1, 1, 3'b100, 17);
        add(0, 1, 3'b001, 5);
        add(0, 0, 3'b001, 1);
        add(0, 1, 3'b100, 4);
        add(0, 1, 3'b010, 1);
        add(0, 0, 3'b001, 1);

        #2;
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset(tbl[i].req);
            tick(tbl[i].req, 0);
            check("vector", {5'b0, outs}, {5'b0, tbl[i].exp});
        end

        // Reset in the 2nd cycle of a pulse, then a full clean boot with no stale ACK
        tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        #3 RESETN = 1'b0;
        #1 check("mid_pulse_reset", {5'b0, outs}, 8'b100);
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RESETN = 1'b1;
        for (int i = 1; i <= S + H + 6; i++) begin
            tick(0, 0);
            check("reboot_preset", {7'b0, PRESET}, {7'b0, i < S + H});
            check("no_stale_ack", {7'b0, ACK}, 8'b0);
        end

        // Sub-cycle RESETN glitch still asserts PRESET and restarts the boot sequence
        #2 RESETN = 1'b0;
        #1 check("glitch_reset", {5'b0, outs}, 8'b100);
        #1 RESETN = 1'b1;
        model_reset();
        for (int i = 1; i <= S + H + 1; i++) tick(0, 0);
        check("glitch_boot_done", {5'b0, outs}, 8'b001);

        // Reset while waiting in ACKW clears ACK asynchronously
        tick(1, 0);
        repeat (4) tick(1, 0);
        check("ackw_reached", {5'b0, outs}, 8'b010);
        #3 RESETN = 1'b0;
        #1 check("ackw_reset", {5'b0, outs}, 8'b100);
        model_reset();
        @(posedge CLK);
        #1 RESETN = 1'b1;
        for (int i = 1; i <= S + H + 4; i++) tick(1, 0);

`ifdef PRESET_SEQ_COUNT_EN
        // Saturation after 300 requests, then clear beats a simultaneous accept
        tick(0, 1);
        for (int i = 0; i < 300; i++) begin
            tick(1, 0);
            repeat (4) tick(1, 0);
            tick(0, 0);
        end
        check("cnt_saturate", PRESET_CNT, 8'd255);
        tick(1, 1);
        check("cnt_clr_priority", PRESET_CNT, 8'd0);
        repeat (4) tick(1, 0);
        tick(0, 0);
`endif

        // Random REQ runs with occasional resets, checked against the model
        do_reset(0);
        begin
            bit r;
            r = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 299) == 0) do_reset(1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) r = ~r;
                tick(r, $urandom_range(0, 49) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
